// File: rtl/custom_ip_deserialiser_pkg.sv
// Shared types and constants for the 4-lane serial receive path.
// Lane order matches the formatter: odd byte on lanes 0/1, even byte on lanes 2/3.
package custom_ip_deserialiser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RECV
    } rx_state_e;

    localparam int unsigned LANES        = 4;
    localparam int unsigned LANE_ODD_LO  = 0;
    localparam int unsigned LANE_ODD_HI  = 1;
    localparam int unsigned LANE_EVEN_LO = 2;
    localparam int unsigned LANE_EVEN_HI = 3;

    function automatic logic [15:0] pack_word(
        input logic [3:0] odd_lo,
        input logic [3:0] odd_hi,
        input logic [3:0] even_lo,
        input logic [3:0] even_hi
    );
        return {odd_hi, odd_lo, even_hi, even_lo};
    endfunction

endpackage

// File: rtl/custom_ip_deserialiser_if.sv
// Output word stream of the deserialiser: valid/ready with a frame-last marker.
interface custom_ip_deserialiser_if;

    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/custom_ip_deserialiser_sync_fifo.sv
// Small synchronous FIFO; full/empty distinguished by an extra pointer wrap bit.
module sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/custom_ip_deserialiser.sv
// Rebuilds 16-bit words from the formatter's 4 nibble-lanes, checks frame length
// and delivers words through a small buffer with sticky error reporting.
module custom_ip_deserialiser
    import custom_ip_deserialiser_pkg::*;
#(
    parameter int unsigned FRAME_GROUPS   = 324,
    parameter int unsigned OUT_FIFO_DEPTH = 4
) (
    input  logic                     clk_fast,
    input  logic                     rst_n,
    input  logic                     ser_enable,
    input  logic [3:0]               ser_data,
    input  logic                     ser_frame_start,
    input  logic                     ser_frame_end,
    custom_ip_deserialiser_if.master m_stream,
    output logic                     frame_ok,
    output logic                     length_error,
    output logic                     overflow_error,
    output logic                     protocol_error,
    input  logic                     err_clr
);

    localparam int unsigned      CNT_W      = $clog2(FRAME_GROUPS + 1);
    localparam logic [CNT_W-1:0] GROUPS_MAX = CNT_W'(FRAME_GROUPS);
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(FRAME_GROUPS - 1);

    rx_state_e        state;
    rx_state_e        state_nxt;
    logic             en_d;
    logic [3:0]       lane_sh  [LANES];
    logic [3:0]       lane_nxt [LANES];
    logic [1:0]       phase;
    logic [CNT_W-1:0] group_cnt;
    logic             frame_err;

    logic             in_recv;
    logic             start_idle;
    logic             restart;
    logic             proto_en;
    logic             proto_end;
    logic             cap;
    logic             grp_done;
    logic             closing;
    logic             excess;
    logic             close_ok;
    logic             close_bad;
    logic             overflow_now;
    logic             len_err_set;

    logic [15:0]      word;
    logic [16:0]      fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ser_frame_start) begin
                    state_nxt = ser_enable ? RECV : ARMED;
                end
            end
            ARMED: begin
                if (ser_enable) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (ser_frame_start) begin
                    state_nxt = ser_enable ? RECV : ARMED;
                end else if (ser_frame_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_recv      = (state == RECV);
        start_idle   = ser_frame_start && (state == IDLE);
        restart      = ser_frame_start && (state != IDLE);
        proto_en     = ser_enable && (state == IDLE) && !ser_frame_start;
        proto_end    = ser_frame_end && !in_recv;
        cap          = en_d && in_recv && !restart;
        grp_done     = cap && (phase == 2'd3);
        closing      = ser_frame_end && in_recv && !restart;
        excess       = grp_done && (group_cnt == GROUPS_MAX);
        close_ok     = closing && grp_done && (group_cnt == LAST_GROUP);
        close_bad    = closing && !close_ok;
        overflow_now = grp_done && fifo_full && !fifo_pop;
        len_err_set  = restart || close_bad || excess;
    end

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_nxt[i] = {lane_sh[i][2:0], ser_data[i]};
        end
        word = pack_word(lane_nxt[LANE_ODD_LO], lane_nxt[LANE_ODD_HI],
                         lane_nxt[LANE_EVEN_LO], lane_nxt[LANE_EVEN_HI]);
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            en_d      <= 1'b0;
            phase     <= '0;
            group_cnt <= '0;
            frame_err <= 1'b0;
            frame_ok  <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_sh[i] <= '0;
            end
        end else begin
            // An enable seen in IDLE is a protocol fault; suppress the capture it would cause.
            en_d     <= ser_enable && !proto_en;
            frame_ok <= close_ok && !frame_err && !overflow_now;
            if (start_idle || restart) begin
                phase     <= '0;
                group_cnt <= '0;
                frame_err <= 1'b0;
            end else begin
                if (cap) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        lane_sh[i] <= lane_nxt[i];
                    end
                    phase <= phase + 2'd1;
                end
                if (grp_done && (group_cnt != GROUPS_MAX)) begin
                    group_cnt <= group_cnt + CNT_W'(1);
                end
                if (excess || overflow_now) begin
                    frame_err <= 1'b1;
                end
                if (closing) begin
                    phase     <= '0;
                    group_cnt <= '0;
                    frame_err <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            length_error   <= 1'b0;
            overflow_error <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (len_err_set) begin
                length_error <= 1'b1;
            end else if (err_clr) begin
                length_error <= 1'b0;
            end
            if (overflow_now) begin
                overflow_error <= 1'b1;
            end else if (err_clr) begin
                overflow_error <= 1'b0;
            end
            if (proto_en || proto_end) begin
                protocol_error <= 1'b1;
            end else if (err_clr) begin
                protocol_error <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (17),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk_fast),
        .rst_n     (rst_n),
        .push      (grp_done),
        .push_data ({closing, word}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        m_stream.m_valid = !fifo_empty;
        fifo_pop         = m_stream.m_valid && m_stream.m_ready;
        m_stream.m_data  = m_stream.m_valid ? fifo_dout[15:0] : '0;
        m_stream.m_last  = m_stream.m_valid && fifo_dout[16];
    end

endmodule

// File: doc/custom_ip_deserialiser.md
Name: custom_ip_deserialiser

Overview:
Receive-side counterpart of the formatter's 4-lane serial output, used in the loopback/verification path and by downstream IP models. Runs on the same fast clock as the serial link. Rebuilds 16-bit words per group ({odd byte, even byte}) from four nibble-lanes and checks frame boundaries and length. Delivers words through a small output buffer on a valid/ready stream and reports sticky error flags.

Parameters:
FRAME_GROUPS, 324, expected groups (16-bit words) per frame
OUT_FIFO_DEPTH, 4, output buffer depth in words; power of two, >=2

Ports:
clk_fast  in  1  serial-link clock (75 MHz)
rst_n  in  1  asynchronous active-low reset
ser_enable  in  1  link enable; high for every stream cycle
ser_data  in  4  lanes: [0] odd[3:0], [1] odd[7:4], [2] even[3:0], [3] even[7:4], MSB first
ser_frame_start  in  1  one-cycle frame start pulse
ser_frame_end  in  1  one-cycle pulse coincident with last data nibble
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  16  [15:8] odd byte, [7:0] even byte
m_last  out  1  marks last word of a frame
frame_ok  out  1  one-cycle pulse: frame closed with exact length and no error
length_error  out  1  sticky: frame closed early/late or with partial group
overflow_error  out  1  sticky: completed word dropped, buffer full
protocol_error  out  1  sticky: ser_enable high outside a frame
err_clr  in  1  synchronous clear of all sticky errors

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, counters 0.
- Link timing: ser_data lags ser_enable by one cycle. Capture qualifier cap = ser_enable registered (en_d). ser_data is sampled only when en_d=1.
- FSM states:
  - IDLE: on ser_frame_start go to ARMED.
  - ARMED: on ser_enable go to RECV. ser_enable coincident with ser_frame_start (zero guard) goes straight from IDLE to RECV.
  - RECV: on ser_frame_end go to IDLE after capturing that cycle's nibble.
  - ser_frame_start in ARMED/RECV: set length_error, discard partial group, restart at ARMED (group count 0). Words already buffered are kept. m_last is not generated for the aborted frame.
- Protocol check: ser_enable=1 in IDLE sets protocol_error. The cycle is ignored. en_d is forced 0 for that cycle.
- Capture: on each cap cycle, shift each lane into its 4-bit register: lane_sh <= {lane_sh[2:0], ser_data[i]}. 2-bit phase counter wraps 3->0.
- Group complete (phase==3 on a cap cycle): word = {lane1_sh', lane0_sh', lane3_sh', lane2_sh'} (post-shift). Push to buffer. group_cnt increments and saturates at FRAME_GROUPS.
- m_last is set on the pushed word when ser_frame_end is in the same cycle.
- Frame close (ser_frame_end in RECV):
  - Require phase==3 on that cycle and group_cnt+1==FRAME_GROUPS.
  - Otherwise set length_error. A partial group is discarded.
  - If checks pass and no error was raised during the frame: frame_ok pulses the next cycle.
- Excess groups beyond FRAME_GROUPS before frame_end: length_error; those words are still pushed.
- Buffer:
  - Synchronous FIFO; m_valid = !empty; pop on m_valid && m_ready.
  - Push when full: word dropped, overflow_error set.
  - Simultaneous push and pop when full is allowed and is not an overflow.
  - Latency: a word is visible on m_data the cycle after the push cycle.
- err_clr clears all sticky flags; a set event in the same cycle wins.
- ser_frame_end outside RECV: ignored, protocol_error set.

Decomposition:
- Shared package: rx_state_e enum (IDLE, ARMED, RECV) and a lane-index constant.
- One sub-module: sync_fifo (WIDTH=17, carrying m_last with data; DEPTH=OUT_FIFO_DEPTH; full/empty by extra pointer bit).

Test Plan:
- FRAME_GROUPS=4, zero guard, words 0x1234,0xABCD,0x0000,0xFFFF serialized with m_ready=1 -> same 4 words out in order, m_last on 0xFFFF only, frame_ok one pulse, no errors.
- Same frame with one guard cycle (start one cycle before enable), back-to-back with an 8-cycle gap -> 8 words, two m_last, two frame_ok.
- frame_end after 3 groups -> 3 words, length_error=1, no frame_ok; err_clr -> length_error=0.
- frame_end mid-group after 2 groups (phase 1) -> 2 words output, partial discarded, length_error=1.
- m_ready=0, OUT_FIFO_DEPTH=4, FRAME_GROUPS=6 -> first 4 words retained, overflow_error=1; after release, exactly 4 words drain.
- ser_enable pulsed in IDLE -> protocol_error=1, no word pushed; reset asserted mid-RECV -> all outputs 0, next clean frame passes.
